fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects and load-use stall control for a 5-stage pipeline.
// Forward is purely combinational; a small IDLE/HOLD FSM stretches each load-use stall to LOAD_LAT cycles.
module fwd_hazard_unit #(
  parameter int REG_AW   = 2,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite_Ex_MEM,
  input  logic                     RegWrite_Mem_WB,
  input  logic                     MemRead_EX,
  input  logic                     RegWrite_EX,
  input  logic [REG_AW-1:0]        Rd_EX,
  input  logic [REG_AW-1:0]        Rd_MEM,
  input  logic [REG_AW-1:0]        Rd_WB,
  input  logic [NSRC*REG_AW-1:0]   Src_ID,
  input  logic [NSRC-1:0]          Src_ID_vld,
  input  logic [NSRC*REG_AW-1:0]   Src_EX,
  input  logic [NSRC-1:0]          Src_EX_vld,
  input  logic                     Flush_in,
  output logic [2*NSRC-1:0]        Forward,
  output logic                     Stall,
  output logic                     Bubble_EX,
  output logic [CNT_W-1:0]         stall_cycles
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [2*NSRC-1:0] w_fwd;
  logic              w_match, w_hazard, w_stall;

  // With ZERO_REG set, register 0 is a constant source that never creates a dependency.
  function automatic logic is_live(input logic [REG_AW-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      logic [REG_AW-1:0] src;
      src = Src_EX[i*REG_AW +: REG_AW];
      if (Src_EX_vld[i] && is_live(src)) begin
        if (RegWrite_Ex_MEM && (Rd_MEM == src))
          w_fwd[2*i +: 2] = 2'b10;
        else if (RegWrite_Mem_WB && (Rd_WB == src))
          w_fwd[2*i +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (Src_ID_vld[i] && (Src_ID[i*REG_AW +: REG_AW] == Rd_EX))
        w_match = 1'b1;
    end
  end

  // A new hazard is only recognised in IDLE; HOLD just runs out its count.
  assign w_hazard = (r_state == IDLE) && MemRead_EX && RegWrite_EX && is_live(Rd_EX) && w_match;
  assign w_stall  = (w_hazard || (r_state == HOLD)) && !Flush_in && !rst;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_hazard && !Flush_in && (LOAD_LAT > 1)) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
        end
      end
      HOLD: begin
        if (Flush_in || (r_cnt == 4'd0))
          w_state_nxt = IDLE;
        else
          w_cnt_nxt = r_cnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall)
        r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign Forward      = w_fwd;
  assign Stall        = w_stall;
  assign Bubble_EX    = w_stall;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: four parameterisations share one stimulus bus.
// Expected values go into a queue as stimulus is applied and are popped when outputs are sampled.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RegWrite_Ex_MEM = 1'b0, RegWrite_Mem_WB = 1'b0, MemRead_EX = 1'b0, RegWrite_EX = 1'b0;
  logic [1:0] Rd_EX = '0, Rd_MEM = '0, Rd_WB = '0;
  logic [3:0] Src_ID = '0, Src_EX = '0;
  logic [1:0] Src_ID_vld = '0, Src_EX_vld = '0;
  logic       Flush_in = 1'b0;

  logic [3:0]  fwd_def, fwd_zr, fwd_l3, fwd_sat;
  logic        stall_def, stall_zr, stall_l3, stall_sat;
  logic        bub_def, bub_zr, bub_l3, bub_sat;
  logic [15:0] cnt_def, cnt_zr, cnt_l3;
  logic [1:0]  cnt_sat;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_def (
    .clk(clk), .rst(rst), .RegWrite_Ex_MEM(RegWrite_Ex_MEM), .RegWrite_Mem_WB(RegWrite_Mem_WB),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .Src_ID(Src_ID), .Src_ID_vld(Src_ID_vld), .Src_EX(Src_EX), .Src_EX_vld(Src_EX_vld),
    .Flush_in(Flush_in), .Forward(fwd_def), .Stall(stall_def), .Bubble_EX(bub_def), .stall_cycles(cnt_def));

  fwd_hazard_unit #(.ZERO_REG(1)) u_zr (
    .clk(clk), .rst(rst), .RegWrite_Ex_MEM(RegWrite_Ex_MEM), .RegWrite_Mem_WB(RegWrite_Mem_WB),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .Src_ID(Src_ID), .Src_ID_vld(Src_ID_vld), .Src_EX(Src_EX), .Src_EX_vld(Src_EX_vld),
    .Flush_in(Flush_in), .Forward(fwd_zr), .Stall(stall_zr), .Bubble_EX(bub_zr), .stall_cycles(cnt_zr));

  fwd_hazard_unit #(.LOAD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .RegWrite_Ex_MEM(RegWrite_Ex_MEM), .RegWrite_Mem_WB(RegWrite_Mem_WB),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .Src_ID(Src_ID), .Src_ID_vld(Src_ID_vld), .Src_EX(Src_EX), .Src_EX_vld(Src_EX_vld),
    .Flush_in(Flush_in), .Forward(fwd_l3), .Stall(stall_l3), .Bubble_EX(bub_l3), .stall_cycles(cnt_l3));

  fwd_hazard_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .RegWrite_Ex_MEM(RegWrite_Ex_MEM), .RegWrite_Mem_WB(RegWrite_Mem_WB),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .Src_ID(Src_ID), .Src_ID_vld(Src_ID_vld), .Src_EX(Src_EX), .Src_EX_vld(Src_EX_vld),
    .Flush_in(Flush_in), .Forward(fwd_sat), .Stall(stall_sat), .Bubble_EX(bub_sat), .stall_cycles(cnt_sat));

  // Reference forwarding select for both operands: MEM beats WB, invalid or masked operands read the file.
  function automatic logic [3:0] ref_fwd(input bit zr);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      logic [1:0] s;
      s = Src_EX[2*i +: 2];
      if (Src_EX_vld[i] && !(zr && s == 2'd0))
        r[2*i +: 2] = (RegWrite_Ex_MEM && Rd_MEM == s) ? 2'b10 :
                      (RegWrite_Mem_WB && Rd_WB == s) ? 2'b01 : 2'b00;
    end
    return r;
  endfunction

  task automatic clear_inputs();
    RegWrite_Ex_MEM = 0; RegWrite_Mem_WB = 0; MemRead_EX = 0; RegWrite_EX = 0;
    Rd_EX = 0; Rd_MEM = 0; Rd_WB = 0; Src_ID = 0; Src_EX = 0;
    Src_ID_vld = 0; Src_EX_vld = 0; Flush_in = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Load to Rd_EX=2 with ID operand 1 reading register 2.
  task automatic drive_load_hazard();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 2'd2;
    Src_ID = 4'b1000; Src_ID_vld = 2'b10;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    drive_load_hazard();
    Src_EX = 4'b0001; Src_EX_vld = 2'b01; RegWrite_Ex_MEM = 1; Rd_MEM = 2'd1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'b0010);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(stall_def) !== exp) begin n_fail++; $display("FAIL rst_stall: got %0d expected %0d", stall_def, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bub_l3) !== exp) begin n_fail++; $display("FAIL rst_bubble: got %0d expected %0d", bub_l3, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(cnt_def) !== exp) begin n_fail++; $display("FAIL rst_count: got %0d expected %0d", cnt_def, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(fwd_def) !== exp) begin n_fail++; $display("FAIL rst_forward: got %b expected %b", fwd_def, exp[3:0]); end
    @(posedge clk); #1;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_checks++;
    if (32'(cnt_l3) !== exp) begin n_fail++; $display("FAIL rst_count_edge: got %0d expected %0d", cnt_l3, exp); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    @(negedge clk);
    Src_EX = 4'b0100; Src_EX_vld = 2'b11;
    RegWrite_Ex_MEM = 1; Rd_MEM = 2'd1; RegWrite_Mem_WB = 1; Rd_WB = 2'd1;
    exp_q.push_back(32'b00); exp_q.push_back(32'b10);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(fwd_def[1:0]) !== exp) begin n_fail++; $display("FAIL fwd_op0: got %b expected %b", fwd_def[1:0], exp[1:0]); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(fwd_def[3:2]) !== exp) begin n_fail++; $display("FAIL fwd_op1_mem: got %b expected %b", fwd_def[3:2], exp[1:0]); end
    @(negedge clk);
    Rd_MEM = 2'd2;
    exp_q.push_back(32'b01);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(fwd_def[3:2]) !== exp) begin n_fail++; $display("FAIL fwd_op1_wb: got %b expected %b", fwd_def[3:2], exp[1:0]); end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      {Src_EX, Src_EX_vld, Rd_MEM, Rd_WB, RegWrite_Ex_MEM, RegWrite_Mem_WB} = 12'($urandom);
      exp_q.push_back(32'(ref_fwd(1'b0)));
      exp_q.push_back(32'(ref_fwd(1'b1)));
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(fwd_def) !== exp) begin n_fail++; $display("FAIL fwd_rand_def[%0d]: got %b expected %b", k, fwd_def, exp[3:0]); end
      exp = exp_q.pop_front(); n_checks++;
      if (32'(fwd_zr) !== exp) begin n_fail++; $display("FAIL fwd_rand_zr[%0d]: got %b expected %b", k, fwd_zr, exp[3:0]); end
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    @(negedge clk);
    RegWrite_Ex_MEM = 1; RegWrite_Mem_WB = 1; Rd_MEM = 0; Rd_WB = 0;
    Src_EX = 4'b0000; Src_EX_vld = 2'b11;
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 0; Src_ID = 4'b0000; Src_ID_vld = 2'b01;
    exp_q.push_back(32'b00); exp_q.push_back(32'd0); exp_q.push_back(32'b1010); exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(fwd_zr[1:0]) !== exp) begin n_fail++; $display("FAIL zr_forward: got %b expected %b", fwd_zr[1:0], exp[1:0]); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(stall_zr) !== exp) begin n_fail++; $display("FAIL zr_stall: got %0d expected %0d", stall_zr, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(fwd_def) !== exp) begin n_fail++; $display("FAIL nozr_forward: got %b expected %b", fwd_def, exp[3:0]); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(stall_def) !== exp) begin n_fail++; $display("FAIL nozr_stall: got %0d expected %0d", stall_def, exp); end
  endtask

  task automatic test_load_lat3();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) drive_load_hazard(); else MemRead_EX = 0;
      exp_q.push_back(32'(c < 3)); exp_q.push_back(32'(c < 3)); exp_q.push_back(32'(c == 0));
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(stall_l3) !== exp) begin n_fail++; $display("FAIL l3_stall c%0d: got %0d expected %0d", c, stall_l3, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (32'(bub_l3) !== exp) begin n_fail++; $display("FAIL l3_bubble c%0d: got %0d expected %0d", c, bub_l3, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (32'(stall_def) !== exp) begin n_fail++; $display("FAIL l1_stall c%0d: got %0d expected %0d", c, stall_def, exp); end
    end
    exp_q.push_back(32'd3);
    exp = exp_q.pop_front(); n_checks++;
    if (32'(cnt_l3) !== exp) begin n_fail++; $display("FAIL l3_count: got %0d expected %0d", cnt_l3, exp); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) drive_load_hazard(); else MemRead_EX = 0;
      Flush_in = (c == 1);
      exp_q.push_back(32'(c == 0));
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(stall_l3) !== exp) begin n_fail++; $display("FAIL flush_hold_stall c%0d: got %0d expected %0d", c, stall_l3, exp); end
    end
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); n_checks++;
    if (32'(cnt_l3) !== exp) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", cnt_l3, exp); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (c == 0) drive_load_hazard(); else MemRead_EX = 0;
      Flush_in = (c == 0);
      exp_q.push_back(32'd0);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(stall_l3) !== exp) begin n_fail++; $display("FAIL flush_idle_stall c%0d: got %0d expected %0d", c, stall_l3, exp); end
    end
    Flush_in = 0;
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); n_checks++;
    if (32'(cnt_l3) !== exp) begin n_fail++; $display("FAIL flush_idle_count: got %0d expected %0d", cnt_l3, exp); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_load_hazard();
      exp_q.push_back(32'd1);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(stall_sat) !== exp) begin n_fail++; $display("FAIL sat_stall_on[%0d]: got %0d expected %0d", k, stall_sat, exp); end
      @(negedge clk);
      MemRead_EX = 0;
      exp_q.push_back(32'(k < 3 ? k + 1 : 3)); exp_q.push_back(32'd0);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(cnt_sat) !== exp) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, cnt_sat, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (32'(stall_sat) !== exp) begin n_fail++; $display("FAIL sat_stall_off[%0d]: got %0d expected %0d", k, stall_sat, exp); end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    @(negedge clk);
    drive_load_hazard();
    @(negedge clk);
    MemRead_EX = 0;
    exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(stall_l3) !== exp) begin n_fail++; $display("FAIL hold_before_rst: got %0d expected %0d", stall_l3, exp); end
    rst = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(stall_l3) !== exp) begin n_fail++; $display("FAIL async_rst_stall: got %0d expected %0d", stall_l3, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(cnt_l3) !== exp) begin n_fail++; $display("FAIL async_rst_count: got %0d expected %0d", cnt_l3, exp); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(stall_l3) !== exp) begin n_fail++; $display("FAIL post_rst_stall c%0d: got %0d expected %0d", c, stall_l3, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (32'(cnt_l3) !== exp) begin n_fail++; $display("FAIL post_rst_count c%0d: got %0d expected %0d", c, cnt_l3, exp); end
      @(negedge clk);
    end
    MemRead_EX = 1;
    exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(stall_l3) !== exp) begin n_fail++; $display("FAIL post_rst_new_hazard: got %0d expected %0d", stall_l3, exp); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_zero_reg();
    test_load_lat3();
    test_flush();
    test_saturation();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
